// File: rtl/axis_frame_gen.sv
// axis_frame_gen: AXI4-Stream video test-pattern generator (x, y, x+y or constant fill), AXIS_FRAME_GEN_MOTION_EN adds a per-frame offset.
// Latency: first pixel valid one cycle after enable is seen in IDLE; tdata is combinational from registered x/y/pattern.
// Backpressure: a beat moves only on tvalid&tready; tdata/tlast/tuser hold while tready=0, blanking counts regardless.
module axis_frame_gen #(
  parameter int BITS = 8
) (
  input  logic            aclk,
  input  logic            areset,
  input  logic            enable,
  input  logic [11:0]     max_x_index,
  input  logic [11:0]     max_y_index,
  input  logic [7:0]      hblank,
  input  logic [11:0]     vblank,
  input  logic [1:0]      pattern,
  input  logic [BITS-1:0] fill_value,
  output logic [BITS-1:0] m_axis_tdata,
  output logic            m_axis_tvalid,
  input  logic            m_axis_tready,
  output logic            m_axis_tlast,
  output logic            m_axis_tuser,
  output logic            frame_done,
  output logic            busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LINE   = 2'd1,
    S_HBLANK = 2'd2,
    S_VBLANK = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Frame geometry and pattern, captured once per frame in IDLE
  logic [11:0]     r_max_x;
  logic [11:0]     r_max_y;
  logic [7:0]      r_hblank;
  logic [11:0]     r_vblank;
  logic [1:0]      r_pattern;
  logic [BITS-1:0] r_fill;

  logic [11:0]     r_x;
  logic [11:0]     r_y;
  logic [11:0]     r_cnt;
  logic            r_frame_done;

  logic            w_accept;
  logic            w_eol;
  logic            w_eof;
  logic [11:0]     w_src;
  logic [BITS-1:0] w_pix;

  assign w_accept = (r_state == S_LINE) && m_axis_tready;
  assign w_eol    = (r_x == r_max_x);
  assign w_eof    = w_eol && (r_y == r_max_y);

  // State register
  always_ff @(posedge aclk) begin
    if (areset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode; blank counters are loaded non-zero, so leaving at 1 gives exactly N idle cycles
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (enable) w_state_nxt = S_LINE;
      S_LINE: begin
        if (w_accept && w_eol) begin
          if (w_eof) w_state_nxt = (r_vblank != 12'd0) ? S_VBLANK : S_IDLE;
          else       w_state_nxt = (r_hblank != 8'd0)  ? S_HBLANK : S_LINE;
        end
      end
      S_HBLANK: if (r_cnt == 12'd1) w_state_nxt = S_LINE;
      S_VBLANK: if (r_cnt == 12'd1) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Stream control outputs decoded from the registered state
  always_comb begin
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = 1'b0;
    busy          = 1'b1;
    case (r_state)
      S_IDLE: busy = 1'b0;
      S_LINE: begin
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = w_eol;
        m_axis_tuser  = (r_x == 12'd0) && (r_y == 12'd0);
      end
      default: ;
    endcase
  end

  // Pixel position, blank counter, configuration capture and end-of-frame pulse
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_max_x      <= '0;
      r_max_y      <= '0;
      r_hblank     <= '0;
      r_vblank     <= '0;
      r_pattern    <= '0;
      r_fill       <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_cnt        <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (enable) begin
            r_max_x   <= max_x_index;
            r_max_y   <= max_y_index;
            r_hblank  <= hblank;
            r_vblank  <= vblank;
            r_pattern <= pattern;
            r_fill    <= fill_value;
            r_x       <= '0;
            r_y       <= '0;
          end
        end
        S_LINE: begin
          if (w_accept) begin
            if (!w_eol) begin
              r_x <= r_x + 12'd1;
            end else begin
              r_x <= '0;
              if (!w_eof) begin
                r_y   <= r_y + 12'd1;
                r_cnt <= {4'd0, r_hblank};
              end else begin
                r_y          <= '0;
                r_cnt        <= r_vblank;
                r_frame_done <= 1'b1;
              end
            end
          end
        end
        S_HBLANK, S_VBLANK: r_cnt <= r_cnt - 12'd1;
        default: ;
      endcase
    end
  end

  // Pattern source in 12 bits; x+y wraps at 4096 before being cut to the pixel width
  always_comb begin
    w_src = r_x;
    case (r_pattern)
      2'd0:    w_src = r_x;
      2'd1:    w_src = r_y;
      default: w_src = r_x + r_y;
    endcase
  end

`ifdef AXIS_FRAME_GEN_MOTION_EN
  logic [7:0] r_frame_cnt;

  // Frame counter: one step per completed frame, wraps naturally at 256
  always_ff @(posedge aclk) begin
    if (areset)            r_frame_cnt <= '0;
    else if (r_frame_done) r_frame_cnt <= r_frame_cnt + 8'd1;
  end

  assign w_pix = BITS'(w_src) + BITS'(r_frame_cnt);
`else
  assign w_pix = BITS'(w_src);
`endif

  assign m_axis_tdata = (r_pattern == 2'd3) ? r_fill : w_pix;
  assign frame_done   = r_frame_done;

endmodule

// File: tb/tb_axis_frame_gen.sv
// tb_axis_frame_gen: table of frame configurations plus hand sequences for stall, enable drop, reset abort and back-to-back frames.
// Expected beats come from a nested x/y loop over the configured geometry; blanking and frame_done timing are counted per cycle.
// Inputs driven and outputs sampled on the falling edge of aclk.
module tb_axis_frame_gen;

`ifdef AXIS_FRAME_GEN_MOTION_EN
  localparam int MOT = 1;
`else
  localparam int MOT = 0;
`endif

  logic        aclk;
  logic        areset;
  logic        enable;
  logic [11:0] max_x_index;
  logic [11:0] max_y_index;
  logic [7:0]  hblank;
  logic [11:0] vblank;
  logic [1:0]  pattern;
  logic [7:0]  fill_value;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        m_axis_tuser;
  logic        frame_done;
  logic        busy;

  axis_frame_gen #(.BITS(8)) dut (
    .aclk          (aclk),
    .areset        (areset),
    .enable        (enable),
    .max_x_index   (max_x_index),
    .max_y_index   (max_y_index),
    .hblank        (hblank),
    .vblank        (vblank),
    .pattern       (pattern),
    .fill_value    (fill_value),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .frame_done    (frame_done),
    .busy          (busy)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    int mx, my, hb, vb, pat, fill, ready_pct;
    int exp_beats, exp_first, exp_last;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic       user;
  } beat_t;

  int n_checks = 0;
  int n_fail   = 0;
  int frames_done = 0;   // frames completed since the last reset (motion offset)

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Pixel value straight from the pattern definition
  function automatic int pix(input int pat, input int x, input int y, input int fill, input int fcnt);
    int v;
    case (pat)
      0:       v = x;
      1:       v = y;
      2:       v = (x + y) % 4096;
      default: return fill % 256;
    endcase
    v = v + MOT * fcnt;
    return v % 256;
  endfunction

  task automatic drive_cfg(input vec_t c);
    max_x_index = 12'(c.mx);
    max_y_index = 12'(c.my);
    hblank      = 8'(c.hb);
    vblank      = 12'(c.vb);
    pattern     = 2'(c.pat);
    fill_value  = 8'(c.fill);
  endtask

  task automatic run_frame(input vec_t c, input int stall_beat, input int stall_len, input int en_drop,
                           output int n_beats, output int first_d, output int last_d);
    beat_t exp_q[$];
    beat_t e;
    int total, accepted, gap, cyc, stall_left, vb_cnt;
    bit after_eol, stalled, done_next;
    logic [7:0] p_data;
    logic p_last, p_user;
    for (int y = 0; y <= c.my; y++)
      for (int x = 0; x <= c.mx; x++) begin
        e.data = 8'(pix(c.pat, x, y, c.fill, frames_done));
        e.last = (x == c.mx);
        e.user = (x == 0) && (y == 0);
        exp_q.push_back(e);
      end
    total = exp_q.size();
    accepted = 0; gap = 0; cyc = 0; stall_left = stall_len;
    after_eol = 0; stalled = 0; done_next = 0;
    p_data = '0; p_last = 0; p_user = 0;
    n_beats = 0; first_d = -1; last_d = -1;
    check("idle_busy", busy, 0);
    drive_cfg(c);
    enable = 1'b1;
    m_axis_tready = 1'b0;
    @(negedge aclk);
    check("start_tvalid", m_axis_tvalid, 1);
    check("start_busy", busy, 1);
    while (!done_next && cyc < 30000) begin
      if (stalled) begin
        check("hold_tvalid", m_axis_tvalid, 1);
        check("hold_tdata", m_axis_tdata, p_data);
        check("hold_tlast", m_axis_tlast, p_last);
        check("hold_tuser", m_axis_tuser, p_user);
      end
      check("frame_done_early", frame_done, 0);
      if (!after_eol) check("tvalid_in_line", m_axis_tvalid, 1);
      if (accepted >= en_drop) enable = 1'b0;
      // configuration inputs wander mid-frame and must be ignored
      max_x_index = 12'($urandom); max_y_index = 12'($urandom);
      hblank = 8'($urandom); vblank = 12'($urandom);
      pattern = 2'($urandom); fill_value = 8'($urandom);
      if (after_eol) begin
        if (m_axis_tvalid) begin
          check("hblank_gap", gap, c.hb);
          after_eol = 0;
          gap = 0;
        end else begin
          gap++;
        end
      end
      if (m_axis_tvalid && accepted == stall_beat && stall_left > 0) begin
        m_axis_tready = 1'b0;
        stall_left--;
      end else begin
        m_axis_tready = ($urandom_range(99) < c.ready_pct);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", accepted + 1, total);
        end else begin
          e = exp_q.pop_front();
          check("tdata", m_axis_tdata, e.data);
          check("tlast", m_axis_tlast, e.last);
          check("tuser", m_axis_tuser, e.user);
          if (accepted == 0) first_d = m_axis_tdata;
          last_d = m_axis_tdata;
          accepted++;
          if (accepted == total) done_next = 1;
          else if (e.last) after_eol = 1;
        end
        stalled = 0;
      end else begin
        stalled = m_axis_tvalid;
      end
      p_data = m_axis_tdata; p_last = m_axis_tlast; p_user = m_axis_tuser;
      @(negedge aclk);
      cyc++;
    end
    n_beats = accepted;
    m_axis_tready = 1'b0;
    if (!done_next) begin
      check("frame_timeout", accepted, total);
      return;
    end
    check("frame_done_pulse", frame_done, 1);
    vb_cnt = 0;
    while (busy && vb_cnt < 5000) begin
      check("vblank_tvalid", m_axis_tvalid, 0);
      vb_cnt++;
      @(negedge aclk);
      check("frame_done_width", frame_done, 0);
    end
    check("vblank_len", vb_cnt, c.vb);
    frames_done++;
    repeat (3) @(negedge aclk);
    check("stay_idle_busy", busy, 0);
    check("stay_idle_done", frame_done, 0);
  endtask

  vec_t tbl[7];
  vec_t cfg1;
  int nb, fd0, ld0, fcnt, seen, cyc, idle_gap, first0, first1;
  bit fd_seen;

  initial begin
    // {mx, my, hb, vb, pat, fill, ready%, beats, first, last}
    tbl[0] = '{3,    1, 2, 0, 0, 0,    100, 8,    0,   3};
    tbl[1] = '{0,    0, 0, 0, 0, 0,    50,  1,    0,   0};
    tbl[2] = '{0,    3, 1, 2, 1, 0,    60,  4,    0,   3};
    tbl[3] = '{299,  0, 0, 3, 2, 0,    80,  300,  0,   43};
    tbl[4] = '{4,    2, 0, 1, 3, 8'hA5, 40, 15,   165, 165};
    tbl[5] = '{2,    4, 3, 0, 2, 0,    70,  15,   0,   6};
    tbl[6] = '{4095, 1, 0, 0, 2, 0,    90,  8192, 0,   0};
    cfg1 = tbl[0];

    areset = 1'b1; enable = 1'b0; m_axis_tready = 1'b0;
    max_x_index = '0; max_y_index = '0; hblank = '0; vblank = '0;
    pattern = '0; fill_value = '0;
    repeat (3) @(negedge aclk);
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tlast", m_axis_tlast, 0);
    check("rst_tuser", m_axis_tuser, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_busy", busy, 0);
    check("rst_tdata", m_axis_tdata, 0);
    areset = 1'b0;
    repeat (2) @(negedge aclk);
    check("idle_no_enable", busy, 0);

    for (int i = 0; i < 7; i++) begin
      int fdm;
      fdm = (tbl[i].pat != 3) ? MOT * frames_done : 0;
      run_frame(tbl[i], -1, 0, 0, nb, fd0, ld0);
      check("tbl_beats", nb, tbl[i].exp_beats);
      check("tbl_first", fd0, (tbl[i].exp_first + fdm) % 256);
      check("tbl_last", ld0, (tbl[i].exp_last + fdm) % 256);
    end

    // three-cycle stall while beat 2 is presented
    run_frame(cfg1, 1, 3, 0, nb, fd0, ld0);
    check("stall_beats", nb, 8);
    // enable held until five pixels have gone, then dropped
    run_frame(cfg1, -1, 0, 5, nb, fd0, ld0);
    check("endrop_beats", nb, 8);

    // reset while pixel 2 of the first line is presented
    drive_cfg(cfg1);
    enable = 1'b1; m_axis_tready = 1'b1;
    @(negedge aclk);
    enable = 1'b0;
    seen = 0; cyc = 0;
    while (seen < 2 && cyc < 50) begin
      if (m_axis_tvalid && m_axis_tready) seen++;
      @(negedge aclk);
      cyc++;
    end
    check("pre_rst_tvalid", m_axis_tvalid, 1);
    check("pre_rst_tdata", m_axis_tdata, (2 + MOT * frames_done) % 256);
    areset = 1'b1;
    @(negedge aclk);
    areset = 1'b0;
    frames_done = 0;
    check("abort_tvalid", m_axis_tvalid, 0);
    check("abort_busy", busy, 0);
    check("abort_tdata", m_axis_tdata, 0);
    check("abort_tuser", m_axis_tuser, 0);
    fd_seen = 0;
    for (int k = 0; k < 20; k++) begin
      if (frame_done) fd_seen = 1;
      if (busy) fd_seen = 1;
      @(negedge aclk);
    end
    check("abort_quiet", fd_seen, 0);
    run_frame(cfg1, -1, 0, 0, nb, fd0, ld0);
    check("after_abort_beats", nb, 8);
    check("after_abort_first", fd0, 0);

    // back-to-back frames with enable held: idle gap and per-frame offset
    areset = 1'b1;
    @(negedge aclk);
    areset = 1'b0;
    frames_done = 0;
    max_x_index = 12'd1; max_y_index = 12'd0; hblank = 8'd0; vblank = 12'd0;
    pattern = 2'd0; fill_value = 8'h00;
    enable = 1'b1; m_axis_tready = 1'b1;
    fcnt = 0; idle_gap = 0; first0 = -1; first1 = -1; cyc = 0;
    while (fcnt < 2 && cyc < 100) begin
      @(negedge aclk);
      cyc++;
      if (frame_done) fcnt++;
      if (fcnt == 1 && !busy) idle_gap++;
      if (m_axis_tvalid && m_axis_tuser) begin
        if (fcnt == 0) first0 = m_axis_tdata;
        else           first1 = m_axis_tdata;
      end
    end
    enable = 1'b0;
    check("b2b_frames", fcnt, 2);
    check("b2b_first0", first0, 0);
    check("b2b_first1", first1, MOT);
    check("b2b_idle_gap", (idle_gap >= 1), 1);
    repeat (3) @(negedge aclk);
    check("b2b_stay_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_frame_gen.md
AXIS_FRAME_GEN -- requirements
Module: axis_frame_gen

Interface
REQ-001 SHALL have parameter BITS, default 8, the pixel data width.
REQ-002 SHALL have port aclk, input, 1, the single clock; all logic rises on its posedge.
REQ-003 SHALL have port areset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port enable, input, 1; level 1 requests continuous frame generation.
REQ-005 SHALL have port max_x_index, input, 12, the frame width minus 1.
REQ-006 SHALL have port max_y_index, input, 12, the frame height minus 1.
REQ-007 SHALL have port hblank, input, 8, the idle cycles between lines.
REQ-008 SHALL have port vblank, input, 12, the idle cycles after a frame.
REQ-009 SHALL have port pattern, input, 2, the test pattern select.
REQ-010 SHALL have port fill_value, input, BITS, the constant used by pattern 3.
REQ-011 SHALL have port m_axis_tdata, output, BITS, the pixel.
REQ-012 SHALL have port m_axis_tvalid, output, 1, pixel valid.
REQ-013 SHALL have port m_axis_tready, input, 1, downstream ready.
REQ-014 SHALL have port m_axis_tlast, output, 1, EOL, asserted on the pixel with x==max_x.
REQ-015 SHALL have port m_axis_tuser, output, 1, SOF, asserted only on pixel (0,0).
REQ-016 SHALL have port frame_done, output, 1, a one-cycle pulse after the last pixel of a frame is accepted.
REQ-017 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-018 SHALL implement the states IDLE, LINE, HBLANK and VBLANK.
REQ-019 IDLE with enable=1 SHALL latch max_x_index, max_y_index, hblank, vblank, pattern and fill_value, clear x and y, and enter LINE on the next cycle.
REQ-020 Latched values SHALL be used for the whole frame; input changes mid-frame SHALL be ignored.
REQ-021 In LINE, m_axis_tvalid SHALL be 1.
REQ-022 A pixel SHALL be accepted only when tvalid and tready are both 1.
REQ-023 While tready=0, tdata, tlast and tuser SHALL hold stable.
REQ-024 On accept with x<max_x, x SHALL increment.
REQ-025 On accept with x==max_x and y<max_y: x SHALL reset to 0 and y SHALL increment; the next state SHALL be HBLANK if hblank>0, else LINE directly with no gap cycle.
REQ-026 On accept with x==max_x and y==max_y: frame_done SHALL pulse the next cycle; the next state SHALL be VBLANK if vblank>0, else IDLE.
REQ-027 HBLANK and VBLANK SHALL hold tvalid=0 for exactly hblank or vblank cycles, then go to LINE or IDLE respectively.
REQ-028 Dropping enable mid-frame SHALL NOT truncate the frame; the current frame and its vblank SHALL complete, and IDLE SHALL then stay IDLE.
REQ-029 There SHALL be at least one IDLE cycle between consecutive frames.
REQ-030 Pixel data SHALL be combinational from the registered x, y and pattern: pattern 0 gives x, 1 gives y, 2 gives x+y, 3 gives fill_value.
REQ-031 The x, y and x+y results SHALL be truncated to the low BITS bits, with 12-bit addition wrapping silently.
REQ-032 max_x=0 SHALL give single-pixel lines with tlast on every pixel.
REQ-033 max_y=0 SHALL give a single-line frame carrying both tuser and tlast on its pixels as applicable.

Reset
REQ-034 On areset=1 at a clock edge, the block SHALL enter IDLE and clear x, y, the blank counter and the latched configuration.
REQ-035 On reset, tvalid, tlast, tuser, frame_done and busy SHALL be 0 and tdata SHALL be 0.
REQ-036 Reset asserted mid-frame SHALL abort the frame immediately, with tvalid=0 on the following cycle and no frame_done.
REQ-037 After reset is released, the first frame SHALL start only through IDLE with enable=1.

Configuration
REQ-038 With macro AXIS_FRAME_GEN_MOTION_EN defined, an 8-bit frame counter SHALL be included.
REQ-039 The frame counter SHALL reset to 0, increment on each frame_done and wrap from 255 to 0.
REQ-040 With AXIS_FRAME_GEN_MOTION_EN defined, the counter value SHALL be added modulo 2^BITS to the pattern 0-2 outputs; pattern 3 SHALL be unaffected.
REQ-041 With AXIS_FRAME_GEN_MOTION_EN undefined, no counter logic SHALL exist and the data SHALL be the pure pattern.

Verification
REQ-042 Basic frame: max_x=3, max_y=1, hblank=2, vblank=0, pattern=0, tready=1 -> tdata 0,1,2,3, 2 gap cycles, 0,1,2,3; tuser on the first beat only; tlast on beats 4 and 8; frame_done 1 cycle after beat 8.
REQ-043 Backpressure: the same configuration with tready=0 for 3 cycles at beat 2 -> tdata=1 and tvalid=1 held for the stall, with no lost or duplicated pixel.
REQ-044 Pattern 2 wrap: BITS=8, max_x=299, y=0 -> tdata at x=256 reads 0; pattern 3 with fill_value=0xA5 gives 0xA5 on every beat.
REQ-045 Enable drop: enable falls at frame pixel 5 of 8 -> all 8 pixels and frame_done are still issued, then the block stays in IDLE with busy=0.
REQ-046 Reset mid-line: areset for 1 cycle at pixel 2 -> tvalid=0 the next cycle, no frame_done, and the next frame starts again with tuser on pixel (0,0).
REQ-047 Motion (macro defined): pattern=0 for two frames -> the first pixel reads 0 in frame 1 and 1 in frame 2; with the macro undefined, both read 0.
